rx_fifo_unloader: RTL and testbench
===================================

Name: rx_fifo_unloader

Overview:
- Read-side consumer of the receive FIFO, running in the MAC Platform receive clock domain.
- Issues reads when the FIFO is non-empty and buffer space exists, and absorbs the one-cycle RAM read latency.
- Buffers words in a small output FIFO and decodes the 4-bit MPDU delimiter tag into SOP/EOP/FCS framing for the RX DMA.
- Tracks per-MPDU word count and framing errors.

Parameters:
- OUTDEPTH, 4, entries of the internal output buffer; legal range 2..8; at 3 or more, sustained rate is one word per cycle.
- CNTWIDTH, 12, width of the per-MPDU word counter and the length output.

Ports:
- macPIRxClk  in  1  MAC Platform receive clock; the only clock of the block.
- macPIClkHardRst_n  in  1  hard reset, asynchronous, active low.
- unloadFlush  in  1  flush request from the DMA control; a one-cycle pulse.
- rxFIFOEmpty  in  1  receive FIFO empty, read-clock domain.
- rxFIFODataValid  in  1  read data valid, one cycle after rxFIFORead.
- rxFIFORdData  in  32  read data word.
- rxFIFOMPDUDelimiters  in  4  tag of the read word.
- rxFIFORead  out  1  read request to the receive FIFO.
- rxFIFORdFlush  out  1  flush to the receive FIFO read side; equals unloadFlush.
- wordValid  out  1  output word available.
- wordReady  in  1  downstream accepts the word.
- wordData  out  32  output word.
- wordSOP  out  1  first word of an MPDU.
- wordEOP  out  1  last word of an MPDU.
- wordFcsOk  out  1  FCS status; meaningful only with wordEOP.
- mpduDone  out  1  one-cycle pulse when an EOP word is accepted.
- mpduWordCnt  out  CNTWIDTH  word count of the completed MPDU; held until the next mpduDone.
- mpduAbort  out  1  one-cycle pulse on a truncated MPDU.
- orphanCnt  out  8  count of words dropped outside an MPDU; saturating.

Behaviour:
- Reset: all outputs are 0. Output buffer is empty, inFlight is 0, state is IDLE, counters are 0.
- Tag encoding:
  - 4'h0: body word.
  - 4'h1: MPDU start.
  - 4'h2: MPDU end, FCS good.
  - 4'h3: MPDU end, FCS bad.
  - 4'hF: discard.
  - Any other value is treated as a body word.
- Read issue: rxFIFORead = !rxFIFOEmpty && !unloadFlush && (bufCount + inFlight < OUTDEPTH).
  - inFlight is 1 exactly when rxFIFORead was high the previous cycle.
  - rxFIFOEmpty already reflects a read issued the previous cycle, so back-to-back reads are legal.
- Capture: rxFIFODataValid pushes {tag, data} into the output buffer. A capture is ignored in the cycle unloadFlush is high.
- Output handshake:
  - The head word is transferred when wordValid && wordReady.
  - wordData, SOP, EOP and FcsOk are stable while wordValid && !wordReady.
  - Push and pop in the same cycle are both performed, and bufCount is unchanged.
- Tag decode is applied on pop, through a state machine with states IDLE and IN_MPDU:
  - IDLE, tag 1: present with SOP=1, go to IN_MPDU, counter = 1.
  - IDLE, tag 0, 2 or 3: word is dropped with wordValid suppressed (popped internally in one cycle), and orphanCnt is incremented.
  - IN_MPDU, tag 0: present, counter += 1.
  - IN_MPDU, tag 2 or 3: present with EOP=1 and wordFcsOk = (tag==2). mpduWordCnt = counter + 1, mpduDone pulses, go to IDLE.
  - IN_MPDU, tag 1: mpduAbort pulses. The word is presented as a new SOP and the counter = 1. The previous MPDU ends without EOP.
  - Any state, tag F: dropped silently; state and counter are unchanged.
- The counter saturates at all ones. mpduWordCnt reports the saturated value.
- Flush (unloadFlush=1):
  - Output buffer cleared, inFlight cleared, and any rxFIFODataValid in that cycle is discarded.
  - If the state is IN_MPDU, mpduAbort pulses and the state goes to IDLE.
  - wordValid is 0 in the next cycle.
  - orphanCnt is kept.
- Reset mid-MPDU: everything returns to the reset values with no pulse.
- Latency: FIFO word ready → rxFIFORead in the same cycle → data captured at the next edge → wordValid high the following cycle. Minimum latency is 2 cycles.

Test Plan:
- Stream: FIFO holds tags 1,0,0,2 with data 0xA0..0xA3 and wordReady=1.
  - Required: 4 words on consecutive cycles, SOP on 0xA0, EOP+FcsOk on 0xA3.
  - mpduDone pulse with mpduWordCnt=4.
  - Reads issued back-to-back.
- Backpressure: wordReady=0 for 10 cycles during a 12-word MPDU with OUTDEPTH=4.
  - Required: at most 4 reads outstanding plus buffered, no word lost, wordData stable while stalled.
  - After release, words are in order and mpduWordCnt=12.
- Bad FCS and discard: tags 1,F,0,3.
  - Required: 3 words presented, EOP with wordFcsOk=0, mpduWordCnt=3.
- Orphans and truncation: tags 0,0,1,0,1,2.
  - Required: orphanCnt=2.
  - mpduAbort pulses on the second start; final mpduWordCnt=2.
- Flush: unloadFlush pulse while rxFIFODataValid=1 in mid-MPDU, with 2 words buffered.
  - Required: rxFIFORdFlush=1 in that cycle and rxFIFORead=0.
  - mpduAbort pulses, wordValid=0 in the next cycle, state is IDLE.
- Async reset: assert macPIClkHardRst_n=0 mid-MPDU with a full buffer.
  - Required: all outputs 0 immediately, with no mpduDone or mpduAbort pulse.

Source files
------------

// File: rtl/rx_fifo_unloader.sv
// rx_fifo_unloader: receive FIFO read-side consumer.
// Buffers RAM reads and decodes MPDU delimiters into SOP/EOP framing.
module rx_fifo_unloader #(
  parameter int OUTDEPTH = 4,
  parameter int CNTWIDTH = 12
) (
  input  logic                macPIRxClk,
  input  logic                macPIClkHardRst_n,
  input  logic                unloadFlush,
  input  logic                rxFIFOEmpty,
  input  logic                rxFIFODataValid,
  input  logic [31:0]         rxFIFORdData,
  input  logic [3:0]          rxFIFOMPDUDelimiters,
  output logic                rxFIFORead,
  output logic                rxFIFORdFlush,
  output logic                wordValid,
  input  logic                wordReady,
  output logic [31:0]         wordData,
  output logic                wordSOP,
  output logic                wordEOP,
  output logic                wordFcsOk,
  output logic                mpduDone,
  output logic [CNTWIDTH-1:0] mpduWordCnt,
  output logic                mpduAbort,
  output logic [7:0]          orphanCnt
);

  localparam int PW = (OUTDEPTH > 2) ? $clog2(OUTDEPTH) : 1;
  localparam int CW = $clog2(OUTDEPTH + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    IN_MPDU = 1'b1
  } state_t;

  state_t              state;
  state_t              stateNxt;
  logic [35:0]         bufMem [OUTDEPTH];
  logic [PW-1:0]       wrPtr;
  logic [PW-1:0]       rdPtr;
  logic [CW-1:0]       bufCount;
  logic [CW:0]         occupancy;
  logic                inFlight;
  logic [CNTWIDTH-1:0] wordCnt;
  logic [CNTWIDTH-1:0] wordCntInc;

  logic                headVld;
  logic [3:0]          headTag;
  logic [31:0]         headData;
  logic                isStart;
  logic                isEnd;
  logic                isDisc;
  logic                present;
  logic                accept;
  logic                drop;
  logic                push;
  logic                pop;
  logic                orphanInc;
  logic                doneNxt;
  logic                abortNxt;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    if (p == PW'(OUTDEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign rxFIFORdFlush = unloadFlush;

  // Reserve a buffer slot for every word read but not yet returned.
  assign occupancy = {1'b0, bufCount} + (CW + 1)'(inFlight);
  assign rxFIFORead = macPIClkHardRst_n & ~rxFIFOEmpty & ~unloadFlush
                    & (occupancy < (CW + 1)'(OUTDEPTH));

  assign push     = rxFIFODataValid & ~unloadFlush;
  assign headVld  = (bufCount != '0);
  assign headTag  = bufMem[rdPtr][35:32];
  assign headData = bufMem[rdPtr][31:0];

  // Delimiter tag classes; unknown tags behave as body words.
  always_comb begin
    isStart = 1'b0;
    isEnd   = 1'b0;
    isDisc  = 1'b0;
    unique case (1'b1)
      (headTag == 4'h1): isStart = 1'b1;
      (headTag == 4'h2),
      (headTag == 4'h3): isEnd   = 1'b1;
      (headTag == 4'hF): isDisc  = 1'b1;
      default: ;
    endcase
  end

  assign wordCntInc = (&wordCnt) ? wordCnt : wordCnt + 1'b1;

  // FSM state register.
  always_ff @(posedge macPIRxClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // FSM next state: framing advances only when a word is handed over.
  always_comb begin
    stateNxt = state;
    if (unloadFlush) begin
      stateNxt = IDLE;
    end else if (accept) begin
      if (isStart) begin
        stateNxt = IN_MPDU;
      end else if (isEnd) begin
        stateNxt = IDLE;
      end
    end
  end

  // FSM outputs: present or silently drop the head word.
  always_comb begin
    present = 1'b0;
    if (headVld) begin
      unique case (state)
        IDLE:    present = isStart;
        IN_MPDU: present = ~isDisc;
        default: present = 1'b0;
      endcase
    end
    wordValid = present & ~unloadFlush;
    wordData  = wordValid ? headData : 32'h0;
    wordSOP   = wordValid & isStart;
    wordEOP   = wordValid & isEnd & (state == IN_MPDU);
    wordFcsOk = wordEOP & (headTag == 4'h2);
    accept    = wordValid & wordReady;
    drop      = headVld & ~present & ~unloadFlush;
    pop       = accept | drop;
    orphanInc = drop & (state == IDLE) & ~isDisc;
    doneNxt   = accept & wordEOP;
    abortNxt  = (state == IN_MPDU)
              & (unloadFlush | (accept & isStart));
  end

  // Output buffer storage; contents are don't-care while empty.
  always_ff @(posedge macPIRxClk) begin
    if (push) begin
      bufMem[wrPtr] <= {rxFIFOMPDUDelimiters, rxFIFORdData};
    end
  end

  // Buffer pointers, occupancy and outstanding read tracking.
  always_ff @(posedge macPIRxClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      bufCount <= '0;
      inFlight <= 1'b0;
    end else if (unloadFlush) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      bufCount <= '0;
      inFlight <= 1'b0;
    end else begin
      inFlight <= rxFIFORead;
      if (push) begin
        wrPtr <= nextPtr(wrPtr);
      end
      if (pop) begin
        rdPtr <= nextPtr(rdPtr);
      end
      unique case ({push, pop})
        2'b10:   bufCount <= bufCount + 1'b1;
        2'b01:   bufCount <= bufCount - 1'b1;
        default: bufCount <= bufCount;
      endcase
    end
  end

  // Per-MPDU word counter, saturating at all ones.
  always_ff @(posedge macPIRxClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      wordCnt <= '0;
    end else if (unloadFlush) begin
      wordCnt <= '0;
    end else if (accept) begin
      if (isStart) begin
        wordCnt <= CNTWIDTH'(1);
      end else if (isEnd) begin
        wordCnt <= '0;
      end else begin
        wordCnt <= wordCntInc;
      end
    end
  end

  // Completion and abort pulses, plus the held MPDU length.
  always_ff @(posedge macPIRxClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      mpduDone    <= 1'b0;
      mpduAbort   <= 1'b0;
      mpduWordCnt <= '0;
    end else begin
      mpduDone  <= doneNxt;
      mpduAbort <= abortNxt;
      if (doneNxt) begin
        mpduWordCnt <= wordCntInc;
      end
    end
  end

  // Saturating count of words seen outside any MPDU.
  always_ff @(posedge macPIRxClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      orphanCnt <= '0;
    end else if (orphanInc && !(&orphanCnt)) begin
      orphanCnt <= orphanCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_fifo_unloader.sv
// tb_rx_fifo_unloader: directed scoreboard bench.
// Models the receive FIFO and checks framing, backpressure, flush, reset.
module tb_rx_fifo_unloader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        unloadFlush;
  logic        rxFIFOEmpty;
  logic        rxFIFODataValid;
  logic [31:0] rxFIFORdData;
  logic [3:0]  rxFIFOMPDUDelimiters;
  logic        rxFIFORead;
  logic        rxFIFORdFlush;
  logic        wordValid;
  logic        wordReady;
  logic [31:0] wordData;
  logic        wordSOP;
  logic        wordEOP;
  logic        wordFcsOk;
  logic        mpduDone;
  logic [11:0] mpduWordCnt;
  logic        mpduAbort;
  logic [7:0]  orphanCnt;

  always #5 clk = ~clk;

  rx_fifo_unloader #(.OUTDEPTH(4), .CNTWIDTH(12)) dut (
    .macPIRxClk(clk),
    .macPIClkHardRst_n(rst_n),
    .unloadFlush(unloadFlush),
    .rxFIFOEmpty(rxFIFOEmpty),
    .rxFIFODataValid(rxFIFODataValid),
    .rxFIFORdData(rxFIFORdData),
    .rxFIFOMPDUDelimiters(rxFIFOMPDUDelimiters),
    .rxFIFORead(rxFIFORead),
    .rxFIFORdFlush(rxFIFORdFlush),
    .wordValid(wordValid),
    .wordReady(wordReady),
    .wordData(wordData),
    .wordSOP(wordSOP),
    .wordEOP(wordEOP),
    .wordFcsOk(wordFcsOk),
    .mpduDone(mpduDone),
    .mpduWordCnt(mpduWordCnt),
    .mpduAbort(mpduAbort),
    .orphanCnt(orphanCnt)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic        fcs;
  } exp_t;

  exp_t        sbQ[$];
  int          doneQ[$];
  logic [35:0] fifoQ[$];

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int rdCnt = 0;
  int accCnt = 0;
  int abortSeen = 0;
  int doneSeen = 0;
  int firstAcc = -1;
  int lastAcc = -1;
  int firstRd = -1;
  int lastRd = -1;
  logic        prevStall = 1'b0;
  logic [31:0] prevData = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] tag, input logic [31:0] d);
    fifoQ.push_back({tag, d});
    rxFIFOEmpty = 1'b0;
  endtask

  task automatic expw(input logic [31:0] d, input logic sop,
                      input logic eop, input logic fcs);
    exp_t e;
    e.d = d;
    e.sop = sop;
    e.eop = eop;
    e.fcs = fcs;
    sbQ.push_back(e);
  endtask

  task automatic tick();
    exp_t        e;
    logic        rd;
    logic        fl;
    logic [35:0] w;
    @(negedge clk);
    rd = rxFIFORead;
    fl = rxFIFORdFlush;
    if (prevStall && wordValid) begin
      check("stall_data", wordData, prevData);
    end
    if (wordValid && wordReady) begin
      if (sbQ.size() == 0) begin
        check("unexpected_word", 32'(sbQ.size()), 32'd1);
      end else begin
        e = sbQ.pop_front();
        check("word_data", wordData, e.d);
        check("word_sop", 32'(wordSOP), 32'(e.sop));
        check("word_eop", 32'(wordEOP), 32'(e.eop));
        if (e.eop) check("word_fcs", 32'(wordFcsOk), 32'(e.fcs));
      end
      accCnt++;
      if (firstAcc < 0) firstAcc = cyc;
      lastAcc = cyc;
    end
    if (mpduDone) begin
      doneSeen++;
      if (doneQ.size() == 0) begin
        check("unexpected_done", 32'(mpduDone), 32'd0);
      end else begin
        check("done_cnt", 32'(mpduWordCnt), 32'(doneQ.pop_front()));
      end
    end
    if (mpduAbort) abortSeen++;
    if (rd) begin
      rdCnt++;
      if (firstRd < 0) firstRd = cyc;
      lastRd = cyc;
    end
    prevStall = wordValid && !wordReady;
    prevData  = wordData;
    @(posedge clk);
    #1;
    cyc++;
    if (fl) begin
      fifoQ.delete();
      rxFIFODataValid = 1'b0;
    end else if (rd && fifoQ.size() > 0) begin
      w = fifoQ.pop_front();
      rxFIFODataValid = 1'b1;
      rxFIFOMPDUDelimiters = w[35:32];
      rxFIFORdData = w[31:0];
    end else begin
      rxFIFODataValid = 1'b0;
    end
    rxFIFOEmpty = (fifoQ.size() == 0);
  endtask

  task automatic drain(input string tag, input int maxc);
    int n;
    n = 0;
    while ((sbQ.size() != 0 || doneQ.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    check(tag, 32'(sbQ.size() + doneQ.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int rd0;
    int ac0;
    int ab0;
    int dn0;
    rst_n = 1'b0;
    unloadFlush = 1'b0;
    rxFIFOEmpty = 1'b1;
    rxFIFODataValid = 1'b0;
    rxFIFORdData = '0;
    rxFIFOMPDUDelimiters = '0;
    wordReady = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    check("rst_wordValid", 32'(wordValid), 32'd0);
    check("rst_rxFIFORead", 32'(rxFIFORead), 32'd0);
    check("rst_mpduDone", 32'(mpduDone), 32'd0);
    check("rst_mpduAbort", 32'(mpduAbort), 32'd0);
    check("rst_mpduWordCnt", 32'(mpduWordCnt), 32'd0);
    check("rst_orphanCnt", 32'(orphanCnt), 32'd0);
    tick();

    // Stream: 1,0,0,2 at full rate.
    firstAcc = -1;
    firstRd = -1;
    rd0 = rdCnt;
    wordReady = 1'b1;
    load(4'h1, 32'hA0); expw(32'hA0, 1, 0, 0);
    load(4'h0, 32'hA1); expw(32'hA1, 0, 0, 0);
    load(4'h0, 32'hA2); expw(32'hA2, 0, 0, 0);
    load(4'h2, 32'hA3); expw(32'hA3, 0, 1, 1);
    doneQ.push_back(4);
    drain("stream_drain", 50);
    check("stream_acc_span", 32'(lastAcc - firstAcc), 32'd3);
    check("stream_rd_span", 32'(lastRd - firstRd), 32'd3);
    check("stream_rd_cnt", 32'(rdCnt - rd0), 32'd4);

    // Backpressure: 12-word MPDU with a 10-cycle stall.
    wordReady = 1'b0;
    rd0 = rdCnt;
    ac0 = accCnt;
    for (int i = 0; i < 12; i++) begin
      load((i == 0) ? 4'h1 : ((i == 11) ? 4'h2 : 4'h0), 32'h100 + i);
      expw(32'h100 + i, i == 0, i == 11, i == 11);
    end
    doneQ.push_back(12);
    repeat (10) tick();
    check("bp_outstanding", 32'((rdCnt - rd0) - (accCnt - ac0)), 32'd4);
    check("bp_valid", 32'(wordValid), 32'd1);
    wordReady = 1'b1;
    drain("bp_drain", 100);

    // Bad FCS with an interleaved discard tag.
    load(4'h1, 32'hB0); expw(32'hB0, 1, 0, 0);
    load(4'hF, 32'hB1);
    load(4'h0, 32'hB2); expw(32'hB2, 0, 0, 0);
    load(4'h3, 32'hB3); expw(32'hB3, 0, 1, 0);
    doneQ.push_back(3);
    drain("fcs_drain", 50);
    check("fcs_orphans", 32'(orphanCnt), 32'd0);

    // Orphans and a truncated MPDU.
    ab0 = abortSeen;
    load(4'h0, 32'hC0);
    load(4'h0, 32'hC1);
    load(4'h1, 32'hC2); expw(32'hC2, 1, 0, 0);
    load(4'h0, 32'hC3); expw(32'hC3, 0, 0, 0);
    load(4'h1, 32'hC4); expw(32'hC4, 1, 0, 0);
    load(4'h2, 32'hC5); expw(32'hC5, 0, 1, 1);
    doneQ.push_back(2);
    drain("orph_drain", 50);
    check("orph_cnt", 32'(orphanCnt), 32'd2);
    check("orph_abort", 32'(abortSeen - ab0), 32'd1);

    // Flush mid-MPDU with two words buffered and one in capture.
    load(4'h1, 32'hD0); expw(32'hD0, 1, 0, 0);
    drain("fl_sop_drain", 20);
    wordReady = 1'b0;
    for (int i = 1; i <= 4; i++) load(4'h0, 32'hD0 + i);
    repeat (3) tick();
    check("fl_pre_valid", 32'(wordValid), 32'd1);
    check("fl_pre_dv", 32'(rxFIFODataValid), 32'd1);
    unloadFlush = 1'b1;
    #1;
    check("fl_rdflush", 32'(rxFIFORdFlush), 32'd1);
    check("fl_read", 32'(rxFIFORead), 32'd0);
    tick();
    unloadFlush = 1'b0;
    #1;
    check("fl_abort", 32'(mpduAbort), 32'd1);
    check("fl_valid_next", 32'(wordValid), 32'd0);
    wordReady = 1'b1;
    load(4'h0, 32'hD9);
    repeat (5) tick();
    check("fl_idle_orphan", 32'(orphanCnt), 32'd3);

    // Async reset mid-MPDU with a full buffer.
    load(4'h1, 32'hE0); expw(32'hE0, 1, 0, 0);
    drain("rst_sop_drain", 20);
    wordReady = 1'b0;
    for (int i = 1; i <= 5; i++) load(4'h0, 32'hE0 + i);
    repeat (6) tick();
    check("ar_pre_valid", 32'(wordValid), 32'd1);
    check("ar_pre_empty", 32'(rxFIFOEmpty), 32'd0);
    ab0 = abortSeen;
    dn0 = doneSeen;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_wordValid", 32'(wordValid), 32'd0);
    check("ar_wordData", wordData, 32'd0);
    check("ar_wordSOP", 32'(wordSOP), 32'd0);
    check("ar_wordEOP", 32'(wordEOP), 32'd0);
    check("ar_wordFcsOk", 32'(wordFcsOk), 32'd0);
    check("ar_rxFIFORead", 32'(rxFIFORead), 32'd0);
    check("ar_mpduDone", 32'(mpduDone), 32'd0);
    check("ar_mpduAbort", 32'(mpduAbort), 32'd0);
    check("ar_mpduWordCnt", 32'(mpduWordCnt), 32'd0);
    check("ar_orphanCnt", 32'(orphanCnt), 32'd0);
    fifoQ.delete();
    rxFIFOEmpty = 1'b1;
    rxFIFODataValid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("ar_no_abort", 32'(abortSeen - ab0), 32'd0);
    check("ar_no_done", 32'(doneSeen - dn0), 32'd0);
    check("ar_post_valid", 32'(wordValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
